// File: rtl/memory_stage_ctrl.sv
// Memory-stage controller: issues dmem requests from the EX/MEM latch, stalls upstream while a
// request is outstanding, loads MEM/WB, and keeps sticky halt plus access/stall counters.
module memory_stage_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_MEM,
    input  logic        RegWr_MEM,
    input  logic [4:0]  wsel_MEM,
    input  logic        memtoReg_MEM,
    input  logic        memWr_MEM,
    input  logic        halt_MEM,
    input  logic [31:0] Output_Port_MEM,
    input  logic [31:0] store_data_MEM,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        valid_WB,
    output logic        RegWr_WB,
    output logic [4:0]  wsel_WB,
    output logic [31:0] wdat_WB,
    output logic        halt,
    output logic [31:0] memop_count,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, HALTED = 2'd2} state_t;
    state_t state, state_next;

    logic        cap_store, cap_regwr;
    logic [4:0]  cap_wsel;
    logic [31:0] cap_addr, cap_data;

    logic        memop, capture, complete, halt_set;
    logic        valid_n, regwr_n;
    logic [4:0]  wsel_n;
    logic [31:0] wdat_n;

    // A load+store combination is treated as a store.
    assign memop = valid_MEM & (memtoReg_MEM | memWr_MEM) & ~halt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        dmemaddr   = '0;
        dmemstore  = '0;
        mem_stall  = 1'b0;
        capture    = 1'b0;
        complete   = 1'b0;
        halt_set   = 1'b0;
        valid_n    = 1'b0;
        regwr_n    = 1'b0;
        wsel_n     = wsel_WB;
        wdat_n     = wdat_WB;
        case (state)
            IDLE: begin
                if (valid_MEM && halt_MEM) begin
                    valid_n    = 1'b1;
                    wsel_n     = wsel_MEM;
                    wdat_n     = Output_Port_MEM;
                    halt_set   = 1'b1;
                    state_next = HALTED;
                end else if (memop) begin
                    dmemREN   = ~memWr_MEM;
                    dmemWEN   = memWr_MEM;
                    dmemaddr  = Output_Port_MEM;
                    dmemstore = store_data_MEM;
                    if (dhit) begin
                        complete = 1'b1;
                        valid_n  = 1'b1;
                        regwr_n  = RegWr_MEM & ~memWr_MEM;
                        wsel_n   = wsel_MEM;
                        wdat_n   = memWr_MEM ? Output_Port_MEM : dmemload;
                    end else begin
                        mem_stall  = 1'b1;
                        capture    = 1'b1;
                        state_next = ACCESS;
                    end
                end else if (valid_MEM) begin
                    valid_n = 1'b1;
                    regwr_n = RegWr_MEM;
                    wsel_n  = wsel_MEM;
                    wdat_n  = Output_Port_MEM;
                end
            end
            ACCESS: begin
                dmemREN   = ~cap_store;
                dmemWEN   = cap_store;
                dmemaddr  = cap_addr;
                dmemstore = cap_data;
                if (dhit) begin
                    complete   = 1'b1;
                    valid_n    = 1'b1;
                    regwr_n    = cap_regwr & ~cap_store;
                    wsel_n     = cap_wsel;
                    wdat_n     = cap_store ? cap_addr : dmemload;
                    state_next = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            HALTED: ;
            default: state_next = IDLE;
        endcase
        // Reset forces the FSM to IDLE at once; keep live inputs from re-raising a request.
        if (RST) begin
            dmemREN   = 1'b0;
            dmemWEN   = 1'b0;
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cap_store   <= 1'b0;
            cap_regwr   <= 1'b0;
            cap_wsel    <= '0;
            cap_addr    <= '0;
            cap_data    <= '0;
            valid_WB    <= 1'b0;
            RegWr_WB    <= 1'b0;
            wsel_WB     <= '0;
            wdat_WB     <= '0;
            halt        <= 1'b0;
            memop_count <= '0;
            stall_count <= '0;
        end else begin
            if (capture) begin
                cap_store <= memWr_MEM;
                cap_regwr <= RegWr_MEM;
                cap_wsel  <= wsel_MEM;
                cap_addr  <= Output_Port_MEM;
                cap_data  <= store_data_MEM;
            end
            valid_WB <= valid_n;
            RegWr_WB <= regwr_n;
            wsel_WB  <= wsel_n;
            wdat_WB  <= wdat_n;
            if (halt_set) halt <= 1'b1;
            if (complete && memop_count != '1) memop_count <= memop_count + 32'd1;
            if (mem_stall && stall_count != '1) stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: doc/memory_stage_ctrl.md
# memory_stage_ctrl

Memory-stage controller on the consuming side of the EX/MEM pipeline latch. It takes the latched EX/MEM fields and issues the data-memory request through the dmem handshake. While a request is outstanding it stalls the upstream pipeline. It then loads the MEM/WB pipeline register with either the load data or the ALU result, and it tracks halt plus two performance counters.

## Interface
Parameters:
- none (word width fixed at 32, register index at 5)

Ports:
- CLK  in  1  pipeline clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- valid_MEM  in  1  EX/MEM slot holds a real instruction
- RegWr_MEM  in  1  instruction writes the register file
- wsel_MEM  in  5  destination register index
- memtoReg_MEM  in  1  instruction is a load
- memWr_MEM  in  1  instruction is a store
- halt_MEM  in  1  instruction is halt
- Output_Port_MEM  in  32  ALU result / effective address
- store_data_MEM  in  32  store data (rt value)
- dhit  in  1  memory completes the current request this cycle
- dmemload  in  32  load data, valid when dhit
- dmemREN  out  1  read request
- dmemWEN  out  1  write request
- dmemaddr  out  32  request address
- dmemstore  out  32  write data
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- valid_WB, RegWr_WB  out  1 each  MEM/WB register fields
- wsel_WB  out  5  MEM/WB destination
- wdat_WB  out  32  MEM/WB write data
- halt  out  1  sticky halt
- memop_count, stall_count  out  32 each  performance counters

## Operation
- Memory op: memop = valid_MEM & (memtoReg_MEM | memWr_MEM) & ~halt. If both memtoReg_MEM and memWr_MEM are set, the instruction is treated as a store; dmemREN=0.
- States: IDLE, ACCESS, HALTED.
- IDLE:
  - Requests are driven combinationally from the MEM inputs: dmemREN = memop & load, dmemWEN = memop & store, dmemaddr = Output_Port_MEM, dmemstore = store_data_MEM.
  - If memop & dhit: the access completes and MEM/WB is loaded this edge; mem_stall=0.
  - If memop & ~dhit: mem_stall=1, the address, data and type are captured, and the state goes to ACCESS.
  - Non-memop valid instruction: MEM/WB is loaded with wdat_WB=Output_Port_MEM.
  - valid_MEM=0: MEM/WB is loaded as a bubble (valid_WB=0, RegWr_WB=0).
- ACCESS:
  - Requests are driven from the captured registers, not the live inputs.
  - mem_stall = ~dhit.
  - While stalled, MEM/WB is loaded as a bubble each edge.
  - On dhit: MEM/WB is loaded with the captured instruction (wdat_WB = dmemload for a load, Output_Port for a store; RegWr_WB forced 0 for stores). Next state is IDLE.
- Halt: a valid halt_MEM in IDLE loads MEM/WB with valid_WB=1, RegWr_WB=0, sets halt, and moves to HALTED.
- HALTED:
  - dmemREN=dmemWEN=0, mem_stall=0.
  - MEM/WB gets bubbles every cycle.
  - Exits only on RST.
- memop_count increments on every completed access (dhit with request active).
- stall_count increments on every cycle with mem_stall=1.
- Both counters saturate at 32'hFFFFFFFF.

## Timing
- Reset (asynchronous, immediate):
  - State=IDLE.
  - dmemREN, dmemWEN, dmemaddr, dmemstore = 0 once in IDLE with valid_MEM=0.
  - mem_stall=0, valid_WB=0, RegWr_WB=0, wsel_WB=0, wdat_WB=0, halt=0, both counters 0.
- RST asserted during ACCESS drops the request in the same cycle. No MEM/WB update occurs for the aborted instruction.
- Latency:
  - Non-memory instruction: 1 cycle, MEM to WB.
  - Memory op: 1 + N cycles, where N is the number of cycles before dhit arrives.
  - Zero-wait hit: 1 cycle, no stall.
- Request stability: in ACCESS, dmemREN/dmemWEN/dmemaddr/dmemstore hold constant until the dhit cycle inclusive.
- Dropping requests: they drop in the cycle after dhit unless a new memop is present in IDLE.
- dhit while no request is active is ignored: no state change, no counter change.
- Back-to-back memops: the next op may request in the cycle immediately after completion.

## Test plan
- Reset in ACCESS: RST during ACCESS with address 0x40 -> dmemREN=0 immediately; the following cycle is IDLE with all outputs and counters 0.
- Zero-wait load: load with address 0x100 and dhit=1 in the same cycle, dmemload=0xDEADBEEF, wsel=8 -> next edge gives valid_WB=1, RegWr_WB=1, wsel_WB=8, wdat_WB=0xDEADBEEF; mem_stall never high; memop_count=1.
- Multi-cycle store: store with address 0x200, data 0x1234, dhit after 3 cycles, with the live inputs changed during the wait:
  - dmemWEN=1, dmemaddr=0x200, dmemstore=0x1234 held all 4 cycles.
  - mem_stall=1 for 3 cycles, stall_count=3.
  - Bubbles in WB during the wait, then valid_WB=1 with RegWr_WB=0.
- ALU passthrough: valid non-memop with Output_Port=0x55, wsel=3 -> next edge gives wdat_WB=0x55, wsel_WB=3, RegWr_WB as input; no dmem request.
- Halt: halt at MEM followed by a load -> halt=1 from the next edge; the load never raises dmemREN; valid_WB=0 every cycle after the halt slot.
- Illegal both-set: memtoReg_MEM=memWr_MEM=1 -> dmemWEN=1, dmemREN=0, RegWr_WB=0 on completion.
